// File: rtl/icm_dma_rd_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// icm_dma_rd_arbiter_pkg
//
// Shared definitions for the ICM-cache DMA read arbiter:
//   DMA_HEAD_WIDTH / DMA_DATA_WIDTH  - DMA request/response head and data widths
//   ICM_DMA_ARB_REQ_NUM              - default number of requesting threads
//   ICM_DMA_ARB_OUTSTANDING_NUM      - default maximum in-flight DMA reads
//   STAT_CNT_WIDTH                   - width of each per-requester grant counter
//   arb_state_e                      - arbiter FSM state encoding
//   log2b()                          - bits needed to hold a value (min 1)
// -----------------------------------------------------------------------------
package icm_dma_rd_arbiter_pkg;

  localparam int DMA_HEAD_WIDTH              = 128;
  localparam int DMA_DATA_WIDTH              = 256;
  localparam int ICM_DMA_ARB_REQ_NUM         = 4;
  localparam int ICM_DMA_ARB_OUTSTANDING_NUM = 16;
  localparam int STAT_CNT_WIDTH              = 32;

  typedef enum logic {
    IDLE_s = 1'b0,
    BUSY_s = 1'b1
  } arb_state_e;

  // Number of bits required to represent 'value'; log2b(REQ_NUM-1) is
  // therefore the index width for REQ_NUM entries. Never returns 0.
  function automatic int log2b(input int unsigned value);
    int width;
    width = 1;
    for (int i = 1; i < 32; i++) begin
      if ((value >> i) != 0) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/icm_dma_rd_arbiter_if.sv
// -----------------------------------------------------------------------------
// icm_dma_rd_arbiter_if
//
// Bundles every handshake/bus signal around the DMA read arbiter:
//   req_*        : per-thread read requests (flattened, thread i at slice i)
//   rsp_*        : per-thread routed responses (same slicing, one-hot valid)
//   dma_rd_req_* : arbitrated request channel towards the DMA engine
//   dma_rd_rsp_* : in-order response channel from the DMA engine
// Modports:
//   master : the environment (cache threads + DMA engine)
//   slave  : the arbiter
// -----------------------------------------------------------------------------
interface icm_dma_rd_arbiter_if
  import icm_dma_rd_arbiter_pkg::*;
#(
  parameter int REQ_NUM = ICM_DMA_ARB_REQ_NUM
) ();

  logic [REQ_NUM-1:0]                req_valid;
  logic [REQ_NUM-1:0]                req_last;
  logic [REQ_NUM*DMA_HEAD_WIDTH-1:0] req_head;
  logic [REQ_NUM*DMA_DATA_WIDTH-1:0] req_data;
  logic [REQ_NUM-1:0]                req_ready;

  logic                              dma_rd_req_valid;
  logic                              dma_rd_req_last;
  logic [DMA_HEAD_WIDTH-1:0]         dma_rd_req_head;
  logic [DMA_DATA_WIDTH-1:0]         dma_rd_req_data;
  logic                              dma_rd_req_ready;

  logic                              dma_rd_rsp_valid;
  logic                              dma_rd_rsp_last;
  logic [DMA_HEAD_WIDTH-1:0]         dma_rd_rsp_head;
  logic [DMA_DATA_WIDTH-1:0]         dma_rd_rsp_data;
  logic                              dma_rd_rsp_ready;

  logic [REQ_NUM-1:0]                rsp_valid;
  logic [REQ_NUM-1:0]                rsp_last;
  logic [REQ_NUM*DMA_HEAD_WIDTH-1:0] rsp_head;
  logic [REQ_NUM*DMA_DATA_WIDTH-1:0] rsp_data;
  logic [REQ_NUM-1:0]                rsp_ready;

  modport master (
    output req_valid, req_last, req_head, req_data,
    input  req_ready,
    input  dma_rd_req_valid, dma_rd_req_last, dma_rd_req_head, dma_rd_req_data,
    output dma_rd_req_ready,
    output dma_rd_rsp_valid, dma_rd_rsp_last, dma_rd_rsp_head, dma_rd_rsp_data,
    input  dma_rd_rsp_ready,
    input  rsp_valid, rsp_last, rsp_head, rsp_data,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_last, req_head, req_data,
    output req_ready,
    output dma_rd_req_valid, dma_rd_req_last, dma_rd_req_head, dma_rd_req_data,
    input  dma_rd_req_ready,
    input  dma_rd_rsp_valid, dma_rd_rsp_last, dma_rd_rsp_head, dma_rd_rsp_data,
    output dma_rd_rsp_ready,
    output rsp_valid, rsp_last, rsp_head, rsp_data,
    input  rsp_ready
  );

endinterface

// File: rtl/icm_dma_rd_arbiter_owner_fifo.sv
// -----------------------------------------------------------------------------
// icm_dma_owner_fifo
//
// Synchronous FIFO recording which requester owns each in-flight DMA read.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write one owner index (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   dout       : head entry (meaningless while empty)
//   full/empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module icm_dma_owner_fifo
  import icm_dma_rd_arbiter_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = ICM_DMA_ARB_OUTSTANDING_NUM
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = log2b(DEPTH - 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t             wr_ptr_q;
  ptr_t             rd_ptr_q;
  cnt_t             count_q;
  logic             push_en;
  logic             pop_en;

  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  assign full  = (count_q == cnt_t'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // NOTE: storage is deliberately left out of reset; the pointers and count
  // alone define which entries are valid, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/icm_dma_rd_arbiter.sv
// -----------------------------------------------------------------------------
// icm_dma_rd_arbiter
//
// Shares the single ICM-cache DMA read request channel between REQ_NUM
// get-processing threads. Round-robin arbitration with packet-level locking:
// a grant is held until the granted thread completes a packet (last beat
// accepted). Each completed packet's owner is pushed into an in-order owner
// FIFO, and the in-order DMA read responses are routed combinationally to the
// owner at the FIFO head, popping on the last response beat.
//
// Ports:
//   clk             : clock
//   rst_n           : asynchronous active-low reset
//   bus (slave)     : request, arbitrated request, DMA response and routed
//                     response channels (see icm_dma_rd_arbiter_if)
// Optional (macro ICM_DMA_ARB_STAT_EN):
//   stat_grant_cnt  : per-requester count of completed request packets,
//                     saturating, requester i at slice i
//   stat_orphan_err : sticky, set when a DMA response arrives with no owner
// -----------------------------------------------------------------------------
module icm_dma_rd_arbiter
  import icm_dma_rd_arbiter_pkg::*;
#(
  parameter int REQ_NUM         = ICM_DMA_ARB_REQ_NUM,
  parameter int OUTSTANDING_NUM = ICM_DMA_ARB_OUTSTANDING_NUM
) (
  input  logic                              clk,
  input  logic                              rst_n,
  icm_dma_rd_arbiter_if.slave               bus
`ifdef ICM_DMA_ARB_STAT_EN
  ,
  output logic [REQ_NUM*STAT_CNT_WIDTH-1:0] stat_grant_cnt,
  output logic                              stat_orphan_err
`endif
);

  localparam int REQ_NUM_LOG = log2b(REQ_NUM - 1);
  localparam int HW          = DMA_HEAD_WIDTH;
  localparam int DW          = DMA_DATA_WIDTH;

  typedef logic [REQ_NUM_LOG-1:0] req_idx_t;

  arb_state_e state_q, state_d;
  req_idx_t   rr_ptr_q, rr_ptr_d;
  req_idx_t   grant_idx_q, grant_idx_d;
  req_idx_t   pick_idx;

  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  req_idx_t   head_owner;

  logic [REQ_NUM-1:0]      arb_req_ready;
  logic                    arb_dma_valid;
  logic                    arb_dma_last;
  logic [HW-1:0]           arb_dma_head;
  logic [DW-1:0]           arb_dma_data;

  logic [REQ_NUM-1:0]      route_valid;
  logic [REQ_NUM-1:0]      route_last;
  logic [REQ_NUM*HW-1:0]   route_head;
  logic [REQ_NUM*DW-1:0]   route_data;
  logic                    route_dma_ready;

  // ---------------------------------------------------------------------------
  // Owner FIFO
  // ---------------------------------------------------------------------------
  icm_dma_owner_fifo #(
    .WIDTH (REQ_NUM_LOG),
    .DEPTH (OUTSTANDING_NUM)
  ) u_owner_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (grant_idx_q),
    .dout  (head_owner),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Arbiter FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE_s;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  always_comb begin
    int cand;
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    cand          = 0;
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_idx_d   = grant_idx_q;
    pick_idx      = rr_ptr_q;
    fifo_push     = 1'b0;
    arb_req_ready = '0;
    arb_dma_valid = 1'b0;
    arb_dma_last  = 1'b0;
    arb_dma_head  = '0;
    arb_dma_data  = '0;

    // Scan from the farthest candidate back to rr_ptr so the last hit, and
    // therefore the surviving one, is the first valid at or after rr_ptr.
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= REQ_NUM) cand = cand - REQ_NUM;
      if (bus.req_valid[req_idx_t'(cand)]) pick_idx = req_idx_t'(cand);
    end

    case (state_q)
      IDLE_s: begin
        // Granting only with FIFO room guarantees the packet's push fits.
        if (|bus.req_valid && !fifo_full) begin
          grant_idx_d = pick_idx;
          state_d     = BUSY_s;
        end
      end
      BUSY_s: begin
        arb_dma_valid              = bus.req_valid[grant_idx_q];
        arb_dma_last               = bus.req_last[grant_idx_q];
        arb_dma_head               = bus.req_head[grant_idx_q*HW +: HW];
        arb_dma_data               = bus.req_data[grant_idx_q*DW +: DW];
        arb_req_ready[grant_idx_q] = bus.dma_rd_req_ready;
        if (arb_dma_valid && bus.dma_rd_req_ready && arb_dma_last) begin
          fifo_push = 1'b1;
          rr_ptr_d  = (grant_idx_q == req_idx_t'(REQ_NUM - 1)) ? '0
                                                               : grant_idx_q + 1'b1;
          state_d   = IDLE_s;
        end
      end
      default: state_d = IDLE_s;
    endcase
  end

  assign bus.req_ready        = arb_req_ready;
  assign bus.dma_rd_req_valid = arb_dma_valid;
  assign bus.dma_rd_req_last  = arb_dma_last;
  assign bus.dma_rd_req_head  = arb_dma_head;
  assign bus.dma_rd_req_data  = arb_dma_data;

  // ---------------------------------------------------------------------------
  // Response routing: purely combinational steer to the FIFO head owner
  // ---------------------------------------------------------------------------
  always_comb begin
    route_valid     = '0;
    route_last      = '0;
    route_head      = '0;
    route_data      = '0;
    route_dma_ready = 1'b0;
    fifo_pop        = 1'b0;
    if (!fifo_empty) begin
      route_valid[head_owner]           = bus.dma_rd_rsp_valid;
      route_last[head_owner]            = bus.dma_rd_rsp_last;
      route_head[head_owner*HW +: HW]   = bus.dma_rd_rsp_head;
      route_data[head_owner*DW +: DW]   = bus.dma_rd_rsp_data;
      route_dma_ready                   = bus.rsp_ready[head_owner];
      fifo_pop = bus.dma_rd_rsp_valid && route_dma_ready && bus.dma_rd_rsp_last;
    end
  end

  assign bus.rsp_valid        = route_valid;
  assign bus.rsp_last         = route_last;
  assign bus.rsp_head         = route_head;
  assign bus.rsp_data         = route_data;
  assign bus.dma_rd_rsp_ready = route_dma_ready;

`ifdef ICM_DMA_ARB_STAT_EN
  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  logic [STAT_CNT_WIDTH-1:0] grant_cnt_q [REQ_NUM];
  logic                      orphan_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REQ_NUM; i++) grant_cnt_q[i] <= '0;
      orphan_err_q <= 1'b0;
    end else begin
      // A push marks exactly one completed packet by grant_idx_q.
      if (fifo_push && (grant_cnt_q[grant_idx_q] != '1)) begin
        grant_cnt_q[grant_idx_q] <= grant_cnt_q[grant_idx_q] + 1'b1;
      end
      if (bus.dma_rd_rsp_valid && fifo_empty) orphan_err_q <= 1'b1;
    end
  end

  for (genvar g = 0; g < REQ_NUM; g++) begin : g_stat_flat
    assign stat_grant_cnt[g*STAT_CNT_WIDTH +: STAT_CNT_WIDTH] = grant_cnt_q[g];
  end

  assign stat_orphan_err = orphan_err_q;
`endif

endmodule

// File: doc/icm_dma_rd_arbiter.md
# icm_dma_rd_arbiter

Shares the single ICM-cache DMA read request channel between REQ_NUM ICM cache get-processing threads (MTT, MPT, QPC, CQC, …) using round-robin arbitration with packet-level locking. Records the owner of every issued read in an in-order tag FIFO, and routes the in-order DMA read responses back to the requester that issued them. Sits between the per-cache get-processing threads and the DMA engine read port in the ICM management subsystem.

## Interface
- REQ_NUM, 4, number of requesting threads (2..8)
- REQ_NUM_LOG, log2b(REQ_NUM - 1), requester index width
- OUTSTANDING_NUM, 16, maximum in-flight reads (power of two)
- OUTSTANDING_NUM_LOG, log2b(OUTSTANDING_NUM - 1), owner FIFO pointer width
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid / req_last  in  REQ_NUM  per-requester request valid / last
- req_head  in  REQ_NUM*`DMA_HEAD_WIDTH  request head, requester i at slice i
- req_data  in  REQ_NUM*`DMA_DATA_WIDTH  request data, requester i at slice i
- req_ready  out  REQ_NUM  per-requester ready
- dma_rd_req_valid / dma_rd_req_last  out  1  arbitrated request valid / last
- dma_rd_req_head / dma_rd_req_data  out  `DMA_HEAD_WIDTH / `DMA_DATA_WIDTH  arbitrated request head / data
- dma_rd_req_ready  in  1  DMA engine ready
- dma_rd_rsp_valid / dma_rd_rsp_last  in  1  response valid / last
- dma_rd_rsp_head / dma_rd_rsp_data  in  `DMA_HEAD_WIDTH / `DMA_DATA_WIDTH  response head / data
- dma_rd_rsp_ready  out  1  response ready
- rsp_valid / rsp_last  out  REQ_NUM  routed response valid / last, one-hot
- rsp_head / rsp_data  out  REQ_NUM*… , same slicing as requests
- rsp_ready  in  REQ_NUM  per-requester response ready

## Operation
- States: IDLE_s, BUSY_s.
- IDLE_s: if any req_valid and the owner FIFO is not full:
  - Pick the first valid requester at or after rr_ptr, wrapping modulo REQ_NUM.
  - Register it as grant_idx and go to BUSY_s.
  - No req_ready is asserted in IDLE_s.
- BUSY_s: pass through requester grant_idx:
  - dma_rd_req_* = req_*[grant_idx].
  - req_ready[grant_idx] = dma_rd_req_ready; all other req_ready = 0.
- On the handshake where valid & ready & last:
  - Push grant_idx into the owner FIFO.
  - Set rr_ptr = grant_idx + 1, wrapping to 0 after REQ_NUM-1.
  - Return to IDLE_s.
- Response path, owner FIFO not empty:
  - rsp_*[head_owner] = dma_rd_rsp_*; all other rsp_valid = 0.
  - dma_rd_rsp_ready = rsp_ready[head_owner].
  - Pop on the dma_rd_rsp handshake with last.
- Owner FIFO empty: dma_rd_rsp_ready = 0, all rsp_valid = 0.
- Simultaneous push and pop in one cycle: both take effect and the occupancy count is unchanged.
- Full: the FIFO is checked only in IDLE_s, before granting. One push per grant, so overflow cannot occur.
- Reset mid-operation:
  - All state is cleared. Any partially sent packet is abandoned.
  - The DMA engine shares rst_n, so no orphan responses arrive.

## Timing
- Request latency: req_valid to dma_rd_req_valid is 1 cycle (the IDLE_s grant cycle).
- Back-to-back packets: 1 idle cycle between packets for re-arbitration.
- Response path is fully combinational: 0-cycle routing latency.
- Handshakes follow valid/ready. The arbiter never drops dma_rd_req_valid while in BUSY_s unless the granted requester drops it.
- Reset values:
  - cur_state = IDLE_s, rr_ptr = 0, grant_idx = 0.
  - FIFO empty.
  - All outputs 0 (valid, ready, last, head, data).

## Configuration
- ICM_DMA_ARB_STAT_EN defined: adds the following, all reset to 0:
  - Output stat_grant_cnt [REQ_NUM*32], a per-requester count of completed request packets. Saturates at 32'hFFFFFFFF.
  - Output stat_orphan_err [1], a sticky flag set when dma_rd_rsp_valid is seen while the owner FIFO is empty.
- ICM_DMA_ARB_STAT_EN undefined: these ports and their logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package / `protocol_engine_def.vh:
  - `DMA_HEAD_WIDTH and `DMA_DATA_WIDTH (existing).
  - log2b.
  - New ICM_DMA_ARB_OUTSTANDING_NUM default constant.
- One sub-module: icm_dma_owner_fifo.
  - Synchronous FIFO, width REQ_NUM_LOG, depth OUTSTANDING_NUM.
  - Ports: push, pop, din, dout, full, empty.
  - Async active-low reset.

## Test plan
- Single requester 2 issues one packet (last=1) → dma_rd_req_valid 1 cycle after req_valid, carrying head of slice 2. Response with last returns on rsp_valid[2] only.
- All 4 requesters valid continuously, dma ready = 1 → grant order 0,1,2,3,0 with one idle cycle between grants.
- Requester 1 issues 3 reads, requester 3 issues 1, interleaved order 1,3,1,1 → in-order responses routed to 1,3,1,1; owner FIFO empty at the end.
- Issue 16 reads with no responses → 17th request stalls in IDLE_s with req_ready = 0. One response pop → grant proceeds on the next cycle.
- rst_n asserted while in BUSY_s mid-packet → all outputs 0 immediately; after release rr_ptr = 0 and FIFO empty.
- With ICM_DMA_ARB_STAT_EN: response sent with FIFO empty → stat_orphan_err = 1 and it stays set. After 5 grants to requester 0, stat_grant_cnt[0] = 5.
